// File: rtl/aes128_host_if.sv
// aes128_host_if
//   Byte-stream front end for an AES-128 core. It accepts a frame on the rx
//   port and drives the loaded key, mode and message into the core. After
//   CORE_LATENCY cycles it samples the core result and returns it as 16 bytes
//   on the tx port. All multi-byte fields are sent MSB byte first.
//
//   Frame layout: cmd, key[16] (only if cmd[1]), msg[16]
//     cmd[0] = mode (0 encrypt, 1 decrypt)
//     cmd[1] = key present; when clear, the last loaded key is reused
//
// Ports
//   clk                  in   rising-edge clock
//   reset                in   asynchronous, active-low reset
//   rx_data/valid/ready       inbound byte stream (valid/ready)
//   tx_data/valid/ready       outbound result stream (valid/ready)
//   core_key             out  128-bit key to the core
//   core_mode            out  0 encrypt, 1 decrypt
//   core_input_message   out  128-bit block to the core
//   core_output_message  in   128-bit result from the core
//   busy                 out  frame in progress
//
// CORE_LATENCY must lie in 1..255.
module aes128_host_if #(
  parameter int CORE_LATENCY = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [127:0] core_key,
  output logic         core_mode,
  output logic [127:0] core_input_message,
  input  logic [127:0] core_output_message,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_KEY  = 3'd1,
    S_MSG  = 3'd2,
    S_WAIT = 3'd3,
    S_TX   = 3'd4
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(CORE_LATENCY - 1);

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_byte_cnt;
  logic [7:0]   r_wait_cnt;
  logic [127:0] r_key;
  logic [127:0] r_msg;
  logic [127:0] r_tx_sh;
  logic         r_mode;

  logic         w_rx_hs;
  logic         w_tx_hs;
  logic         w_last_byte;
  logic         w_capture;

  // byte_cnt wraps 15->0 on the 16th transfer, which is also the state exit,
  // so every multi-byte state starts counting from zero.
  assign w_last_byte = (r_byte_cnt == 4'hf);
  assign w_capture   = (r_state == S_WAIT) && (r_wait_cnt == LAT_M1);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_CMD;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------
  // Next state and state-decoded outputs. Handshake decisions use the raw
  // valid/ready inputs inside each arm so the decoded outputs never depend
  // on rx_valid or tx_ready.
  // ---------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_CMD: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
        if (rx_valid) w_next = rx_data[1] ? S_KEY : S_MSG;
      end
      S_KEY: begin
        rx_ready = 1'b1;
        if (rx_valid && w_last_byte) w_next = S_MSG;
      end
      S_MSG: begin
        rx_ready = 1'b1;
        if (rx_valid && w_last_byte) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_capture) w_next = S_TX;
      end
      S_TX: begin
        tx_valid = 1'b1;
        if (tx_ready && w_last_byte) w_next = S_CMD;
      end
      default: w_next = S_CMD;
    endcase
  end

  assign w_rx_hs = rx_valid & rx_ready;
  assign w_tx_hs = tx_valid & tx_ready;

  // ---------------------------------------------------------------------
  // Datapath: shift registers, counters and result capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt <= 4'd0;
      r_wait_cnt <= 8'd0;
      r_key      <= '0;
      r_msg      <= '0;
      r_tx_sh    <= '0;
      r_mode     <= 1'b0;
    end else begin
      if (r_state == S_CMD && w_rx_hs) r_mode <= rx_data[0];
      if (r_state == S_KEY && w_rx_hs) r_key  <= {r_key[119:0], rx_data};
      if (r_state == S_MSG && w_rx_hs) r_msg  <= {r_msg[119:0], rx_data};

      if (((r_state == S_KEY || r_state == S_MSG) && w_rx_hs) || w_tx_hs)
        r_byte_cnt <= r_byte_cnt + 4'd1;

      // Zero everywhere but S_WAIT, so it is already clear on entry.
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 8'd1 : 8'd0;

      if (w_capture)    r_tx_sh <= core_output_message;
      else if (w_tx_hs) r_tx_sh <= {r_tx_sh[119:0], 8'h00};
    end
  end

  // Core inputs come straight from the shift registers; the core is only
  // sampled once they have been stable for CORE_LATENCY cycles.
  assign core_key           = r_key;
  assign core_mode          = r_mode;
  assign core_input_message = r_msg;
  assign tx_data            = r_tx_sh[127:120];

endmodule

// File: tb/tb_aes128_host_if.sv
module tb_aes128_host_if;

  localparam int LAT = 11;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [127:0] core_key;
  logic         core_mode;
  logic [127:0] core_input_message;
  logic [127:0] core_output_message;
  logic         busy;

  aes128_host_if #(.CORE_LATENCY(LAT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .core_key            (core_key),
    .core_mode           (core_mode),
    .core_input_message  (core_input_message),
    .core_output_message (core_output_message),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_e = 0;
  logic [7:0]   stall_byte;
  logic [127:0] m_key;

  // ---------------------------------------------------------------------
  // Behavioural AES-128 (tables built from GF(2^8) arithmetic)
  // ---------------------------------------------------------------------
  logic [7:0] sbox [256];
  logic [7:0] isbox[256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] y, xb, s;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      y = 8'h01;
      for (int k = 0; k < 254; k++) y = gm(y, xb);
      if (x == 0) y = 8'h00;
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = xb;
    end
  endtask

  function automatic logic [127:0] sub_b(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = v[127-8*i -: 8];
      o[127-8*i -: 8] = inv ? isbox[b] : sbox[b];
    end
    return o;
  endfunction

  function automatic logic [127:0] shr(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c+r)%4)) -: 8];
        else      o[127-8*(r+4*((c+r)%4)) -: 8] = v[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8]; a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8]; a3 = v[103-32*c -: 8];
      if (!inv) begin
        o[127-32*c -: 8] = gm(a0,2) ^ gm(a1,3) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ gm(a1,2) ^ gm(a2,3) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ gm(a2,2) ^ gm(a3,3);
        o[103-32*c -: 8] = gm(a0,3) ^ a1 ^ a2 ^ gm(a3,2);
      end else begin
        o[127-32*c -: 8] = gm(a0,14) ^ gm(a1,11) ^ gm(a2,13) ^ gm(a3,9);
        o[119-32*c -: 8] = gm(a0,9)  ^ gm(a1,14) ^ gm(a2,11) ^ gm(a3,13);
        o[111-32*c -: 8] = gm(a0,13) ^ gm(a1,9)  ^ gm(a2,14) ^ gm(a3,11);
        o[103-32*c -: 8] = gm(a0,11) ^ gm(a1,13) ^ gm(a2,9)  ^ gm(a3,14);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] key, input logic dec,
                                       input logic [127:0] din);
    logic [31:0]  w[44];
    logic [127:0] rk[11];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    st = din;
    if (!dec) begin
      st ^= rk[0];
      for (int r = 1; r <= 10; r++) begin
        st = shr(sub_b(st, 1'b0), 1'b0);
        if (r < 10) st = mix(st, 1'b0);
        st ^= rk[r];
      end
    end else begin
      st ^= rk[10];
      for (int r = 9; r >= 0; r--) begin
        st = sub_b(shr(st, 1'b1), 1'b1);
        st ^= rk[r];
        if (r > 0) st = mix(st, 1'b1);
      end
    end
    return st;
  endfunction

  // Core stand-in: result appears LAT-1 registers after the inputs settle,
  // so sampling one cycle early would pick up a stale value.
  logic [127:0] cpipe[LAT-1];
  always @(posedge clk) begin
    cpipe[0] <= aes(core_key, core_mode, core_input_message);
    for (int i = 1; i < LAT-1; i++) cpipe[i] <= cpipe[i-1];
  end
  assign core_output_message = cpipe[LAT-2];

  // ---------------------------------------------------------------------
  // Check / stimulus helpers (driven and sampled on the falling edge)
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    forever begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 0) rx_valid = 1'b0;
      else begin rx_valid = 1'b1; rx_data = b; end
      if (rx_valid && rx_ready) begin
        last_e = cyc + 1;
        @(posedge clk);
        return;
      end
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL rx_timeout byte=%h rx_ready never seen", b);
        return;
      end
    end
  endtask

  // bp: 0 always ready, 1 random ready, 2 stall 5 cycles on byte index 5
  // while holding rx_valid high.
  task automatic recv(input int bp, output logic [127:0] res);
    int got = 0, n = 0, first = -1, lastacc = 0, stall = 0;
    bit pend = 0;
    logic [7:0] held = 8'h00;
    res = '0;
    while (got < 16 && n < 2000) begin
      @(negedge clk); n++;
      rx_valid = (bp == 2);
      rx_data  = 8'($urandom);
      if (bp == 2) begin
        chk("bp_rx_ready_low", 128'(rx_ready), 128'(0));
        chk("bp_busy", 128'(busy), 128'(1));
      end
      if (pend) begin
        chk("tx_hold_valid", 128'(tx_valid), 128'(1));
        chk("tx_hold_data", 128'(tx_data), 128'(held));
      end
      if (tx_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("latency", 128'(first), 128'(last_e + LAT));
        end
        case (bp)
          0: tx_ready = 1'b1;
          1: tx_ready = 1'($urandom_range(0, 1));
          default: begin
            if (got == 5 && stall < 5) begin
              tx_ready = 1'b0; stall++; stall_byte = tx_data;
            end else tx_ready = 1'b1;
          end
        endcase
        if (tx_ready) begin
          res = {res[119:0], tx_data}; got++; lastacc = cyc; pend = 0;
        end else begin
          pend = 1; held = tx_data;
        end
      end else tx_ready = 1'($urandom_range(0, 1));
    end
    if (got < 16) begin
      checks++; errors++;
      $display("FAIL tx_timeout bytes=%0d required=16", got);
    end
    if (bp == 0) chk("tx_consecutive", 128'(lastacc), 128'(first + 15));
    @(negedge clk);
    rx_valid = 1'b0; tx_ready = 1'b0;
    chk("post_rx_ready", 128'(rx_ready), 128'(1));
    chk("post_busy", 128'(busy), 128'(0));
    chk("post_tx_valid", 128'(tx_valid), 128'(0));
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [127:0] key,
                           input logic [127:0] msg, input bit gaps, input int bp,
                           output logic [127:0] res);
    send_byte(cmd, 1'b0);
    if (cmd[1]) for (int i = 0; i < 16; i++) send_byte(key[127-8*i -: 8], gaps);
    for (int i = 0; i < 16; i++) send_byte(msg[127-8*i -: 8], gaps);
    recv(bp, res);
  endtask

  task automatic check_core(input logic [7:0] cmd, input logic [127:0] msg);
    chk("core_key", core_key, m_key);
    chk("core_mode", 128'(core_mode), 128'(cmd[0]));
    chk("core_msg", core_input_message, msg);
  endtask

  typedef struct {
    logic [7:0]   cmd;
    logic [127:0] key;
    logic [127:0] msg;
    logic [127:0] exp;
    bit           gaps;
    int           bp;
  } vec_t;

  localparam logic [127:0] FK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FPT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FCT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, exp, k, m;
    logic [7:0] cmd;
    bit gaps;
    int bp;

    tbl[0] = '{8'h02, FK, FPT, FCT, 1'b0, 0};  // encrypt, new key, latency
    tbl[1] = '{8'h01, '0, FCT, FPT, 1'b0, 0};  // decrypt, key reused
    tbl[2] = '{8'h00, '0, FPT, FCT, 1'b1, 2};  // gaps + backpressure
    tbl[3] = '{8'hfe, CK, CPT, CCT, 1'b1, 1};  // upper cmd bits ignored
    tbl[4] = '{8'h03, CK, CCT, CPT, 1'b1, 1};  // decrypt, new key

    build_sbox();
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 128'(rx_ready), 128'(1));
    chk("rst_tx_valid", 128'(tx_valid), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_core_key", core_key, '0);
    chk("rst_core_mode", 128'(core_mode), 128'(0));
    chk("rst_core_msg", core_input_message, '0);
    reset = 1'b1;
    m_key = '0;

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t].cmd, tbl[t].key, tbl[t].msg, tbl[t].gaps, tbl[t].bp, res);
      if (tbl[t].cmd[1]) m_key = tbl[t].key;
      chk($sformatf("vec%0d_result", t), res, tbl[t].exp);
      check_core(tbl[t].cmd, tbl[t].msg);
      if (tbl[t].bp == 2) chk("bp_stall_byte", 128'(stall_byte), 128'(8'hdc));
    end

    // Reset after 8 key bytes: everything clears without a clock edge.
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(CK[127-8*i -: 8], 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midkey_core_key", core_key, '0);
    chk("midkey_rx_ready", 128'(rx_ready), 128'(1));
    chk("midkey_busy", 128'(busy), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    m_key = '0;
    run_frame(8'h02, FK, FPT, 1'b0, 0, res);
    m_key = FK;
    chk("after_reset_result", res, FCT);
    check_core(8'h02, FPT);

    // Randomized frames against the behavioural model.
    for (int r = 0; r < 8; r++) begin
      cmd = 8'($urandom);
      if (r == 0) cmd[1] = 1'b1;
      k = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      gaps = 1'($urandom_range(0, 1));
      bp = $urandom_range(0, 1);
      if (cmd[1]) m_key = k;
      exp = aes(m_key, cmd[0], m);
      run_frame(cmd, k, m, gaps, bp, res);
      chk($sformatf("rand%0d_result", r), res, exp);
      check_core(cmd, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_host_if.md
# aes128_host_if

Byte-stream host interface that loads an `aes128_top` instance and returns its result. It accepts a framed byte stream (command, optional key, message) on a valid/ready input port and drives `key`/`mode`/`input_message` into the core. After a fixed core latency it captures `output_message` and serializes it back as 16 bytes on a valid/ready output port. It sits between a byte transport (UART or bus bridge) and the AES-128 core.

## Interface

**Parameters**
- `CORE_LATENCY`, default 11: cycles from the last message byte to sampling `core_output_message`; legal range 1..255.

**Ports**
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  incoming frame byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts a byte this cycle.
- `tx_data`  out  8  result byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts `tx_data`.
- `core_key`  out  128  to `aes128_top.key`.
- `core_mode`  out  1  to `aes128_top.mode`; 0 = encrypt, 1 = decrypt.
- `core_input_message`  out  128  to `aes128_top.input_message`.
- `core_output_message`  in  128  from `aes128_top.output_message`.
- `busy`  out  1  frame in progress (state is not S_CMD).

## Operation

- **Frame format.** One command byte, then 16 key bytes only if cmd[1]=1, then 16 message bytes. All multi-byte fields are sent MSB byte first.
- **Command byte.**
  - cmd[0] is the mode.
  - cmd[1] = key-present. When it is 0, the previously loaded key is reused.
  - cmd[7:2] are ignored.
- **Handshakes.** A byte transfers on a rising edge with `rx_valid & rx_ready`. An output byte transfers with `tx_valid & tx_ready`.
- **State machine.**
  - S_CMD: `rx_ready`=1. On handshake, `core_mode`<=cmd[0]. Go to S_KEY if cmd[1]=1, else S_MSG.
  - S_KEY: `rx_ready`=1. Each handshake does `core_key` <= {`core_key`[119:0], `rx_data`}. After the 16th byte, go to S_MSG.
  - S_MSG: `rx_ready`=1. Same shift into `core_input_message`. After the 16th byte, go to S_WAIT and clear `wait_cnt`.
  - S_WAIT: `rx_ready`=0. `wait_cnt` increments each cycle. On the cycle where `wait_cnt`==CORE_LATENCY-1: `tx_sh`<=`core_output_message`, then go to S_TX.
  - S_TX: `tx_valid`=1 and `tx_data`=`tx_sh`[127:120]. Each output handshake shifts `tx_sh` left 8 bits. After the 16th byte, go to S_CMD.
- **Counters.**
  - `byte_cnt` is 4 bits. It increments on each data handshake in S_KEY, S_MSG and S_TX, and wraps 15->0. The wrap marks the state exit, so it is 0 on entry to every state.
  - `wait_cnt` is 8 bits.
- **Core input behaviour.** Core inputs are driven straight from the shift registers, so they change while loading. Core output is only sampled in S_WAIT, after all inputs have been stable for CORE_LATENCY cycles.
- **Key retention.** The key persists across frames until a frame with cmd[1]=1 arrives or reset is asserted.
- **Handshake rules.**
  - `rx_data` is ignored when `rx_ready`=0, with no error.
  - `tx_valid` stays asserted and `tx_data` stays stable until accepted. It never drops mid-byte.

## Timing

- **Reset values.** On `reset`=0, asynchronously:
  - state = S_CMD and `byte_cnt`/`wait_cnt` = 0.
  - `rx_ready`=1, `tx_valid`=0, `tx_data`=8'h00, `busy`=0.
  - `core_key`=0, `core_mode`=0, `core_input_message`=0, and `tx_sh`=0.
- **Reset mid-frame.** Any partial frame or partial transmission is discarded. The first byte accepted after reset release is a command byte.
- **Throughput.** One byte per cycle in each direction when the peer is always ready.
- **Latency.** Let E be the edge that accepts the last message byte. `tx_valid` rises after edge E+CORE_LATENCY. The first output byte transfers at the earliest on edge E+CORE_LATENCY+1.
- **Frame length.** A full encrypt frame with a new key takes 33 input cycles + CORE_LATENCY + 16 output cycles. `rx_ready` rises in the cycle after the 16th output handshake.
- **Outputs are registered.** `tx_data` is `tx_sh`[127:120] (register), and `rx_ready`, `tx_valid` and `busy` are decoded from the state register only. There is no combinational path from `rx_valid` or `tx_ready` to any output.

## Test plan

- **Encrypt, new key.**
  - Stimulus: cmd 0x02, key 2b7e151628aed2a6abf7158809cf4f3c, message 3243f6a8885a308d313198a2e0370734.
  - Required response: `tx_data` sequence 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32, with `core_mode`=0.
- **Decrypt, reused key.**
  - Stimulus: immediately after the encrypt frame, cmd 0x01 then message 3925841d02dc09fbdc118597196a0b32.
  - Required response: output 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34, and `core_key` unchanged.
- **Latency check.**
  - Stimulus: CORE_LATENCY=11, `tx_ready`=1.
  - Required response: `tx_valid` rises exactly 11 edges after the last message handshake, and 16 consecutive bytes follow.
- **Backpressure.**
  - Stimulus: `tx_ready`=0 for 5 cycles while byte index 5 (0xdc) is presented; hold `rx_valid`=1 throughout.
  - Required response: `tx_data` holds 0xdc, `tx_valid` stays 1, `rx_ready` stays 0, no byte is lost or duplicated, and `busy`=1.
- **Input gaps.**
  - Stimulus: `rx_valid` toggled randomly 50% during key/message load.
  - Required response: the result is identical to the gapless case.
- **Reset mid-key.**
  - Stimulus: assert `reset` after 8 key bytes.
  - Required response: `core_key`=0, `rx_ready`=1 and `busy`=0 immediately (asynchronously). A subsequent full encrypt frame yields the 3925841d... result.
